// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command sequencer: opcode bytes, reply
// bytes, the sequencer state encoding and a length-decode helper.
package uart_cmd_pkg;

    // Opcode bytes accepted in IDLE
    localparam logic [7:0] OP_LOAD = 8'h4C;   // 'L'
    localparam logic [7:0] OP_DUMP = 8'h44;   // 'D'
    localparam logic [7:0] OP_RUN  = 8'h52;   // 'R'
    localparam logic [7:0] OP_HALT = 8'h48;   // 'H'

    // Reply bytes
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        LOAD,
        DUMP_RD,
        DUMP_TX,
        DUMP_WAIT,
        SEND_RSP,
        WAIT_RSP
    } state_t;

    // A length byte of zero stands for a full 256-byte transfer.
    function automatic logic [8:0] len_from_byte(input logic [7:0] b);
        return (b == 8'h00) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout
// Idle-cycle watchdog for the command sequencer. Counts enabled cycles and
// flags expiry on the TIMEOUT_CYCLES-th cycle without a clear.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en_i         count while high; counter is held at zero while low
//   clear_i      restart the count (a byte arrived)
//   expired_o    high in the cycle the limit is reached
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of idle cycles already elapsed, so the limit is
    // reached while it reads TIMEOUT_CYCLES-1.
    assign expired_o = en_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || clear_i || expired_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Command-driven host controller for the UART debug path. Decodes opcode
// bytes from the receiver and sequences I-memory byte loads, D-memory byte
// dumps to the transmitter, and CPU run/halt, replying ACK/NAK as needed.
// Optional feature macro: UART_CMD_TIMEOUT_EN (argument/data idle timeout).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_ready, rx_data     received byte strobe and byte
//   tx_empty, tx_error    transmitter idle / protocol error
//   tx_req, tx_data       transmit request pulse and registered byte
//   dmem_byte             D-memory read data (cycle after dmem_rd_en)
//   cpu_rst               CPU held in reset when high
//   imem_ctrl/wr_en/addr  I-memory ownership, write strobe, byte address
//   dmem_ctrl/rd_en/addr  D-memory ownership, read strobe, byte address
//   busy, err_flag        not-IDLE indicator, sticky error flag
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int IMEM_BYTE_ADDR_WIDTH = 6,
    parameter int DMEM_BYTE_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES       = 2**20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx_ready,
    input  logic [7:0]                      rx_data,
    input  logic                            tx_empty,
    input  logic                            tx_error,
    output logic                            tx_req,
    output logic [7:0]                      tx_data,
    input  logic [7:0]                      dmem_byte,
    output logic                            cpu_rst,
    output logic                            imem_ctrl,
    output logic                            imem_wr_en,
    output logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_addr,
    output logic                            dmem_ctrl,
    output logic                            dmem_rd_en,
    output logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_addr,
    output logic                            busy,
    output logic                            err_flag
);

    localparam int IW = IMEM_BYTE_ADDR_WIDTH;
    localparam int DW = DMEM_BYTE_ADDR_WIDTH;

    state_t          state_q;
    logic            is_load_q;     // current transfer is 'L' (else 'D')
    logic [8:0]      count_q;       // bytes remaining, 1..256
    logic [1:0]      guard_q;       // cycles of tx_empty still to ignore
    logic [7:0]      rsp_q;         // pending reply byte
    logic            tx_req_q;
    logic [7:0]      tx_data_q;
    logic            cpu_rst_q;
    logic            imem_ctrl_q;
    logic            imem_wr_en_q;
    logic [IW-1:0]   imem_addr_q;
    logic            dmem_ctrl_q;
    logic            dmem_rd_en_q;
    logic [DW-1:0]   dmem_addr_q;
    logic            err_q;
    logic            timeout_hit;

`ifdef UART_CMD_TIMEOUT_EN
    logic timeout_en;
    assign timeout_en = (state_q == GET_ADDR) || (state_q == GET_LEN) || (state_q == LOAD);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (timeout_en),
        .clear_i   (rx_ready),
        .expired_o (timeout_hit)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            count_q      <= '0;
            guard_q      <= '0;
            rsp_q        <= '0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            cpu_rst_q    <= 1'b1;
            imem_ctrl_q  <= 1'b0;
            imem_wr_en_q <= 1'b0;
            imem_addr_q  <= '0;
            dmem_ctrl_q  <= 1'b0;
            dmem_rd_en_q <= 1'b0;
            dmem_addr_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            tx_req_q     <= 1'b0;
            imem_wr_en_q <= 1'b0;
            dmem_rd_en_q <= 1'b0;

            // The address advances in the cycle after the write it served,
            // so imem_addr is correct while imem_wr_en is high.
            if (imem_wr_en_q) begin
                imem_addr_q <= imem_addr_q + IW'(1);
            end
            if (guard_q != 2'd0) begin
                guard_q <= guard_q - 2'd1;
            end

            if (tx_error) begin
                state_q     <= IDLE;
                err_q       <= 1'b1;
                imem_ctrl_q <= 1'b0;
                dmem_ctrl_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_q       <= RSP_NAK;
                err_q       <= 1'b1;
                imem_ctrl_q <= 1'b0;
                dmem_ctrl_q <= 1'b0;
                state_q     <= SEND_RSP;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_ready) begin
                            state_q <= SEND_RSP;
                            if (rx_data == OP_RUN) begin
                                cpu_rst_q <= 1'b0;
                                err_q     <= 1'b0;
                                rsp_q     <= RSP_ACK;
                            end else if (rx_data == OP_HALT) begin
                                cpu_rst_q <= 1'b1;
                                err_q     <= 1'b0;
                                rsp_q     <= RSP_ACK;
                            end else if ((rx_data == OP_LOAD || rx_data == OP_DUMP) && cpu_rst_q) begin
                                err_q       <= 1'b0;
                                is_load_q   <= (rx_data == OP_LOAD);
                                imem_ctrl_q <= (rx_data == OP_LOAD);
                                dmem_ctrl_q <= (rx_data == OP_DUMP);
                                state_q     <= GET_ADDR;
                            end else begin
                                // Unknown opcode, or memory access while the CPU runs.
                                err_q <= 1'b1;
                                rsp_q <= RSP_NAK;
                            end
                        end
                    end
                    GET_ADDR: begin
                        if (rx_ready) begin
                            if (is_load_q) begin
                                imem_addr_q <= IW'(rx_data);
                            end else begin
                                dmem_addr_q <= DW'(rx_data);
                            end
                            state_q <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        if (rx_ready) begin
                            count_q <= len_from_byte(rx_data);
                            if (is_load_q) begin
                                state_q <= LOAD;
                            end else begin
                                dmem_rd_en_q <= 1'b1;
                                state_q      <= DUMP_RD;
                            end
                        end
                    end
                    LOAD: begin
                        if (rx_ready) begin
                            imem_wr_en_q <= 1'b1;
                            count_q      <= count_q - 9'd1;
                            if (count_q == 9'd1) begin
                                rsp_q   <= RSP_ACK;
                                state_q <= SEND_RSP;
                            end
                        end
                    end
                    DUMP_RD: begin
                        // dmem_rd_en is high during this state; data follows.
                        state_q <= DUMP_TX;
                    end
                    DUMP_TX: begin
                        if (tx_empty) begin
                            tx_data_q <= dmem_byte;
                            tx_req_q  <= 1'b1;
                            guard_q   <= 2'd2;
                            state_q   <= DUMP_WAIT;
                        end
                    end
                    DUMP_WAIT: begin
                        // Skip the tx_req cycle and the one after, before the
                        // transmitter has had a chance to drop tx_empty.
                        if (guard_q == 2'd0 && tx_empty) begin
                            dmem_addr_q <= dmem_addr_q + DW'(1);
                            count_q     <= count_q - 9'd1;
                            if (count_q == 9'd1) begin
                                dmem_ctrl_q <= 1'b0;
                                state_q     <= IDLE;
                            end else begin
                                dmem_rd_en_q <= 1'b1;
                                state_q      <= DUMP_RD;
                            end
                        end
                    end
                    SEND_RSP: begin
                        if (tx_empty) begin
                            tx_data_q <= rsp_q;
                            tx_req_q  <= 1'b1;
                            guard_q   <= 2'd2;
                            state_q   <= WAIT_RSP;
                        end
                    end
                    WAIT_RSP: begin
                        if (guard_q == 2'd0 && tx_empty) begin
                            imem_ctrl_q <= 1'b0;
                            dmem_ctrl_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign cpu_rst    = cpu_rst_q;
    assign imem_ctrl  = imem_ctrl_q;
    assign imem_wr_en = imem_wr_en_q;
    assign imem_addr  = imem_addr_q;
    assign dmem_ctrl  = dmem_ctrl_q;
    assign dmem_rd_en = dmem_rd_en_q;
    assign dmem_addr  = dmem_addr_q;
    assign busy       = (state_q != IDLE);
    assign err_flag   = err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
// Directed bench for uart_cmd_sequencer with a byte transmitter model,
// a D-memory read model and an I-memory write recorder.
// The timeout scenario is compiled in when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_empty = 1'b1;
    logic       tx_error = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic [7:0] dmem_byte = 8'h00;
    logic       cpu_rst;
    logic       imem_ctrl;
    logic       imem_wr_en;
    logic [5:0] imem_addr;
    logic       dmem_ctrl;
    logic       dmem_rd_en;
    logic [5:0] dmem_addr;
    logic       busy;
    logic       err_flag;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [7:0] txq[$];
    logic [5:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] dmem [0:63];
    int tx_busy = 0;
    int rd_cnt = 0;
    int bad_ctrl = 0;
    int bad_req = 0;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(
        .IMEM_BYTE_ADDR_WIDTH (6),
        .DMEM_BYTE_ADDR_WIDTH (6),
        .TIMEOUT_CYCLES       (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_empty   (tx_empty),
        .tx_error   (tx_error),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .dmem_byte  (dmem_byte),
        .cpu_rst    (cpu_rst),
        .imem_ctrl  (imem_ctrl),
        .imem_wr_en (imem_wr_en),
        .imem_addr  (imem_addr),
        .dmem_ctrl  (dmem_ctrl),
        .dmem_rd_en (dmem_rd_en),
        .dmem_addr  (dmem_addr),
        .busy       (busy),
        .err_flag   (err_flag)
    );

    // Transmitter, D-memory and I-memory models, all sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_req) begin
            if (!tx_empty) bad_req++;
            txq.push_back(tx_data);
            $display("tx byte 0x%02h", tx_data);
            tx_empty = 1'b0;
            tx_busy  = 6;
        end else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) tx_empty = 1'b1;
        end
        if (dmem_rd_en) begin
            dmem_byte = dmem[dmem_addr];
            rd_cnt++;
        end
        if (imem_wr_en) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(rx_data);
            $display("imem write addr 0x%02h data 0x%02h", imem_addr, rx_data);
            if (!imem_ctrl) bad_ctrl++;
        end
        if (imem_wr_en && dmem_rd_en) bad_ctrl++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        $display("rx byte 0x%02h", b);
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Bounded wait for the next transmitted byte.
    task automatic get_tx(output logic [7:0] b, output bit ok);
        int n = 0;
        while (txq.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (txq.size() != 0);
        b  = ok ? txq.pop_front() : 8'hxx;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
        check_cnt++; if ({tx_req, imem_ctrl, imem_wr_en, dmem_ctrl, dmem_rd_en, busy, err_flag} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {tx_req, imem_ctrl, imem_wr_en, dmem_ctrl, dmem_rd_en, busy, err_flag});
        else pass_cnt++;
        check_cnt++; if ({tx_data, imem_addr, dmem_addr} !== 20'h0) $display("FAIL reset_data: got %h want 0", {tx_data, imem_addr, dmem_addr}); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_run_halt();
        logic [7:0] b; bit ok;
        send_byte(8'h52, 0);
        check_cnt++; if (cpu_rst !== 1'b0) $display("FAIL run_cpu_rst: got %b want 0", cpu_rst); else pass_cnt++;
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h06) $display("FAIL run_ack: got %h want 06", b); else pass_cnt++;
        wait_idle();
        send_byte(8'h48, 0);
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h06) $display("FAIL halt_ack: got %h want 06", b); else pass_cnt++;
        wait_idle();
        check_cnt++; if (cpu_rst !== 1'b1) $display("FAIL halt_cpu_rst: got %b want 1", cpu_rst); else pass_cnt++;
    endtask

    task automatic test_load();
        logic [7:0] b; bit ok;
        logic [5:0] exp_addr [4] = '{6'h3E, 6'h3F, 6'h00, 6'h01};
        logic [7:0] exp_data [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wr_addr_q.delete(); wr_data_q.delete(); bad_ctrl = 0;
        send_byte(8'h4C, 1);
        check_cnt++; if (imem_ctrl !== 1'b1 || dmem_ctrl !== 1'b0) $display("FAIL load_ctrl: got imem %b dmem %b want 1 0", imem_ctrl, dmem_ctrl); else pass_cnt++;
        send_byte(8'h3E, 1);
        send_byte(8'h04, 1);
        for (int i = 0; i < 4; i++) send_byte(exp_data[i], 3);
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h06) $display("FAIL load_ack: got %h want 06", b); else pass_cnt++;
        wait_idle();
        check_cnt++; if (wr_addr_q.size() != 4) $display("FAIL load_count: got %0d writes want 4", wr_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check_cnt++;
            if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i])
                $display("FAIL load_write%0d: got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
            else pass_cnt++;
        end
        check_cnt++; if (bad_ctrl != 0) $display("FAIL load_ownership: got %0d bad strobes want 0", bad_ctrl); else pass_cnt++;
        check_cnt++; if (imem_ctrl !== 1'b0 || err_flag !== 1'b0) $display("FAIL load_release: got ctrl %b err %b want 0 0", imem_ctrl, err_flag); else pass_cnt++;
    endtask

    task automatic test_dump();
        int n = 0;
        for (int i = 0; i < 4; i++) dmem[i] = 8'h10 + 8'(i);
        txq.delete(); rd_cnt = 0; bad_req = 0; bad_ctrl = 0;
        send_byte(8'h44, 1);
        check_cnt++; if (dmem_ctrl !== 1'b1) $display("FAIL dump_ctrl: got %b want 1", dmem_ctrl); else pass_cnt++;
        send_byte(8'h00, 1);
        send_byte(8'h04, 0);
        while (busy && n < 2000) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        check_cnt++; if (txq.size() != 4) $display("FAIL dump_count: got %0d bytes want 4", txq.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            check_cnt++;
            if (txq[i] !== 8'h10 + 8'(i)) $display("FAIL dump_byte%0d: got %h want %h", i, txq[i], 8'h10 + 8'(i)); else pass_cnt++;
        end
        check_cnt++; if (rd_cnt != 4) $display("FAIL dump_reads: got %0d want 4", rd_cnt); else pass_cnt++;
        check_cnt++; if (bad_req != 0 || bad_ctrl != 0) $display("FAIL dump_handshake: got %0d/%0d want 0/0", bad_req, bad_ctrl); else pass_cnt++;
        check_cnt++; if (dmem_ctrl !== 1'b0 || busy !== 1'b0) $display("FAIL dump_release: got ctrl %b busy %b want 0 0", dmem_ctrl, busy); else pass_cnt++;
        txq.delete();
    endtask

    task automatic test_reject();
        logic [7:0] b; bit ok;
        send_byte(8'h52, 0); get_tx(b, ok); wait_idle();
        send_byte(8'h4C, 0);
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h15) $display("FAIL load_running_nak: got %h want 15", b); else pass_cnt++;
        wait_idle();
        check_cnt++; if (err_flag !== 1'b1 || imem_ctrl !== 1'b0) $display("FAIL load_running_err: got err %b ctrl %b want 1 0", err_flag, imem_ctrl); else pass_cnt++;
        send_byte(8'h48, 0);
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h06) $display("FAIL halt_after_nak: got %h want 06", b); else pass_cnt++;
        wait_idle();
        check_cnt++; if (err_flag !== 1'b0) $display("FAIL err_clear: got %b want 0", err_flag); else pass_cnt++;
        send_byte(8'h7F, 0);
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h15) $display("FAIL bad_opcode_nak: got %h want 15", b); else pass_cnt++;
        wait_idle();
        check_cnt++; if (err_flag !== 1'b1) $display("FAIL bad_opcode_err: got %b want 1", err_flag); else pass_cnt++;
    endtask

    task automatic test_drop();
        logic [7:0] b; bit ok;
        txq.delete();
        send_byte(8'h52, 1);
        send_byte(8'h7F, 0);        // arrives during the reply, must vanish
        get_tx(b, ok);
        check_cnt++; if (!ok || b !== 8'h06) $display("FAIL drop_ack: got %h want 06", b); else pass_cnt++;
        wait_idle();
        repeat (30) @(negedge clk);
        check_cnt++; if (txq.size() != 0 || err_flag !== 1'b0) $display("FAIL drop_ignored: got %0d extra bytes err %b want 0 0", txq.size(), err_flag); else pass_cnt++;
        send_byte(8'h48, 0); get_tx(b, ok); wait_idle();
    endtask

    task automatic test_tx_error();
        int n = 0;
        txq.delete();
        send_byte(8'h44, 1);
        send_byte(8'h00, 1);
        send_byte(8'h04, 0);
        while (txq.size() == 0 && n < 2000) begin @(negedge clk); n++; end
        tx_error = 1'b1;
        @(negedge clk);
        tx_error = 1'b0;
        check_cnt++; if (busy !== 1'b0 || dmem_ctrl !== 1'b0) $display("FAIL txerr_abort: got busy %b ctrl %b want 0 0", busy, dmem_ctrl); else pass_cnt++;
        check_cnt++; if (err_flag !== 1'b1 || cpu_rst !== 1'b1) $display("FAIL txerr_flags: got err %b cpu_rst %b want 1 1", err_flag, cpu_rst); else pass_cnt++;
        repeat (60) @(negedge clk);
        check_cnt++; if (txq.size() != 1) $display("FAIL txerr_stop: got %0d bytes want 1", txq.size()); else pass_cnt++;
        txq.delete();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h4C, 1);
        send_byte(8'h05, 1);
        rst_n = 1'b0;
        #1;
        check_cnt++; if (busy !== 1'b0 || imem_ctrl !== 1'b0 || cpu_rst !== 1'b1 || err_flag !== 1'b0)
            $display("FAIL reset_mid: got busy %b ctrl %b cpu_rst %b err %b want 0 0 1 0", busy, imem_ctrl, cpu_rst, err_flag);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        txq.delete();
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        txq.delete();
        send_byte(8'h4C, 0);
        send_byte(8'h00, 0);
        while (txq.size() == 0 && n < 1000) begin @(negedge clk); n++; end
        check_cnt++; if (n < 95 || n > 110) $display("FAIL timeout_latency: got %0d cycles want about 100", n); else pass_cnt++;
        check_cnt++; if (txq.size() == 0 || txq[0] !== 8'h15) $display("FAIL timeout_nak: got %0d bytes want 15", txq.size()); else pass_cnt++;
        check_cnt++; if (imem_ctrl !== 1'b0 || err_flag !== 1'b1) $display("FAIL timeout_state: got ctrl %b err %b want 0 1", imem_ctrl, err_flag); else pass_cnt++;
        wait_idle();
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 8'hE0 ^ 8'(i);
        test_reset();
        test_run_halt();
        test_load();
        test_dump();
        test_reject();
        test_drop();
        test_tx_error();
        test_reset_mid();
`ifdef UART_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
